// File: rtl/pipe_collider.sv
// pipe_collider: per-frame game referee.
//   Stage 0 captures pipe geometry and bird position on frame_tick, stage 1
//   evaluates overlap/past/ahead flags, and stage 2 runs the IDLE/PLAY/DEAD
//   FSM together with the BCD score, best score and the pulse outputs.
// Ports:
//   clk, reset (sync, active-high), frame_tick (1/frame), start (level, IDLE only)
//   pipe_x, pipe_y0 (gap bottom), pipe_y1 (gap top), bird_y (bird top edge)
//   playing, game_over (state levels), collide, score_pulse (1-cycle pulses)
//   score, best (3-digit packed BCD)
// Optional macro: PIPE_COLLIDER_FLOOR_EN makes touching the floor or the
//   ceiling a hit too.
module pipe_collider #(
  parameter int N           = 10,
  parameter int PIPE_WIDTH  = 1,
  parameter int BIRD_SIZE   = 15,
  parameter int BIRD_X      = 160,
  parameter int SCREEN_H    = 480,
  parameter int HOLD_FRAMES = 60
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic         start,
  input  logic [N-1:0] pipe_x,
  input  logic [N-1:0] pipe_y0,
  input  logic [N-1:0] pipe_y1,
  input  logic [N-1:0] bird_y,
  output logic         playing,
  output logic         game_over,
  output logic         collide,
  output logic         score_pulse,
  output logic [11:0]  score,
  output logic [11:0]  best
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  // all geometry is evaluated one bit wider so sums never wrap
  localparam logic [N:0] BIRD_L = (N+1)'(BIRD_X);
  localparam logic [N:0] BIRD_R = (N+1)'(BIRD_X + BIRD_SIZE);
  localparam logic [N:0] PW     = (N+1)'(PIPE_WIDTH);
  localparam logic [N:0] BS     = (N+1)'(BIRD_SIZE);
`ifdef PIPE_COLLIDER_FLOOR_EN
  localparam logic [N:0] SCR_H  = (N+1)'(SCREEN_H);
`endif

  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

  // valid shift register: [0] = stage-0 data valid, [1] = stage-1 flags valid
  logic [1:0]   vld_q, vld_d;
  logic [N-1:0] px_q, py0_q, py1_q, by_q;
  logic [N-1:0] px_d, py0_d, py1_d, by_d;
  logic         hit_q, past_q, ahead_q;
  logic         hit_d, past_d, ahead_d;

  state_t       state_q, state_d;
  logic [11:0]  score_q, score_d, best_q, best_d;
  logic         passed_q, passed_d;
  logic [HW-1:0] hold_q, hold_d;
  logic         collide_q, collide_d, spulse_q, spulse_d;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (r[3:0] == 4'd9) begin
        r[3:0] = 4'd0;
        if (r[7:4] == 4'd9) begin
          r[7:4]  = 4'd0;
          r[11:8] = r[11:8] + 4'd1;
        end else begin
          r[7:4] = r[7:4] + 4'd1;
        end
      end else begin
        r[3:0] = r[3:0] + 4'd1;
      end
    end
    return r;
  endfunction

  // stage 0: capture
  always_comb begin
    vld_d = {vld_q[0], frame_tick};
    px_d  = px_q;
    py0_d = py0_q;
    py1_d = py1_q;
    by_d  = by_q;
    if (frame_tick) begin
      px_d  = pipe_x;
      py0_d = pipe_y0;
      py1_d = pipe_y1;
      by_d  = bird_y;
    end
  end

  // stage 1: geometry flags
  always_comb begin
    logic [N:0] px, py0, py1, by;
    logic       h_ovl, v_out;
    px      = {1'b0, px_q};
    py0     = {1'b0, py0_q};
    py1     = {1'b0, py1_q};
    by      = {1'b0, by_q};
    h_ovl   = (px < BIRD_R) && (px + PW > BIRD_L);
    v_out   = (by < py1) || (by + BS > py0);
    hit_d   = h_ovl && v_out;
`ifdef PIPE_COLLIDER_FLOOR_EN
    if ((by + BS >= SCR_H) || (by == '0)) hit_d = 1'b1;
`endif
    past_d  = (px + PW <= BIRD_L);
    ahead_d = (px >= BIRD_R);
  end

  // stage 2: game FSM
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    best_d    = best_q;
    passed_d  = passed_q;
    hold_d    = hold_q;
    collide_d = 1'b0;
    spulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PLAY;
          score_d  = 12'h000;
          passed_d = 1'b0;
        end
      end
      PLAY: begin
        if (vld_q[1]) begin
          if (hit_q) begin
            state_d   = DEAD;
            collide_d = 1'b1;
            hold_d    = '0;
            if (score_q > best_q) best_d = score_q;
          end else begin
            if (past_q && !passed_q) begin
              passed_d = 1'b1;
              score_d  = bcd_inc(score_q);
              spulse_d = 1'b1;
            end
            if (ahead_q) passed_d = 1'b0;
          end
        end
      end
      DEAD: begin
        if (vld_q[1]) begin
          if (hold_q == HW'(HOLD_FRAMES - 1)) state_d = IDLE;
          else hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      px_q      <= '0;
      py0_q     <= '0;
      py1_q     <= '0;
      by_q      <= '0;
      hit_q     <= 1'b0;
      past_q    <= 1'b0;
      ahead_q   <= 1'b0;
      state_q   <= IDLE;
      score_q   <= 12'h000;
      best_q    <= 12'h000;
      passed_q  <= 1'b0;
      hold_q    <= '0;
      collide_q <= 1'b0;
      spulse_q  <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      px_q      <= px_d;
      py0_q     <= py0_d;
      py1_q     <= py1_d;
      by_q      <= by_d;
      hit_q     <= hit_d;
      past_q    <= past_d;
      ahead_q   <= ahead_d;
      state_q   <= state_d;
      score_q   <= score_d;
      best_q    <= best_d;
      passed_q  <= passed_d;
      hold_q    <= hold_d;
      collide_q <= collide_d;
      spulse_q  <= spulse_d;
    end
  end

  assign playing     = (state_q == PLAY);
  assign game_over   = (state_q == DEAD);
  assign collide     = collide_q;
  assign score_pulse = spulse_q;
  assign score       = score_q;
  assign best        = best_q;

endmodule

// File: tb/tb_pipe_collider.sv
// Directed bench for pipe_collider: reset, scoring, collision, hold timing,
// BCD carry/saturation, floor option and reset in DEAD.
module tb_pipe_collider;
  logic        clk = 1'b0;
  logic        reset, frame_tick, start;
  logic [9:0]  pipe_x, pipe_y0, pipe_y1, bird_y;
  logic        playing, game_over, collide, score_pulse;
  logic [11:0] score, best;

  int total = 0;
  int bad   = 0;
  int ncol, nsp, csum, ssum;

  always #5 clk = ~clk;

  pipe_collider dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .pipe_x(pipe_x), .pipe_y0(pipe_y0), .pipe_y1(pipe_y1), .bird_y(bird_y),
    .playing(playing), .game_over(game_over), .collide(collide),
    .score_pulse(score_pulse), .score(score), .best(best)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  // one frame; counts pulses over the four cycles after the tick
  task automatic frame(input int x, input int by, output int nc, output int ns);
    nc = 0;
    ns = 0;
    @(negedge clk);
    pipe_x = 10'(x); pipe_y0 = 10'd260; pipe_y1 = 10'd200; bird_y = 10'(by);
    frame_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      nc += int'(collide);
      ns += int'(score_pulse);
    end
  endtask

  task automatic pass_one(output int ns);
    int c0, c1, s1;
    frame(140, 220, c0, ns);
    frame(200, 220, c1, s1);
    ns += s1;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_play"}, 12'(playing), 12'h0);
    chk({tag, "_over"}, 12'(game_over), 12'h0);
    chk({tag, "_col"}, 12'(collide), 12'h0);
    chk({tag, "_sp"}, 12'(score_pulse), 12'h0);
    chk({tag, "_score"}, score, 12'h000);
    chk({tag, "_best"}, best, 12'h000);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
    pipe_x = '0; pipe_y0 = '0; pipe_y1 = '0; bird_y = 10'd220;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst");

    do_start();
    chk("start_play", 12'(playing), 12'h1);
    chk("start_score", score, 12'h000);

    frame(200, 220, ncol, nsp);
    chk("far_col", 12'(ncol), 12'h0);
    frame(165, 220, ncol, nsp);
    chk("gap_col", 12'(ncol), 12'h0);
    chk("gap_sp", 12'(nsp), 12'h0);
    frame(140, 220, ncol, nsp);
    chk("pass_sp", 12'(nsp), 12'h1);
    chk("pass_score", score, 12'h001);
    frame(140, 220, ncol, nsp);
    frame(140, 220, ncol, ssum);
    chk("repass_sp", 12'(nsp + ssum), 12'h0);
    chk("repass_score", score, 12'h001);

    // upper-pipe strike
    frame(165, 190, ncol, nsp);
    chk("hit_col", 12'(ncol), 12'h1);
    chk("hit_over", 12'(game_over), 12'h1);
    chk("hit_best", best, 12'h001);

    // start held through 59 hold frames must be ignored
    start = 1'b1;
    for (int i = 0; i < 59; i++) frame(165, 190, ncol, nsp);
    chk("hold_over", 12'(game_over), 12'h1);
    chk("hold_play", 12'(playing), 12'h0);
    start = 1'b0;
    frame(165, 190, ncol, nsp);
    chk("idle_over", 12'(game_over), 12'h0);
    chk("idle_play", 12'(playing), 12'h0);
    chk("idle_score", score, 12'h001);
    chk("idle_best", best, 12'h001);

    do_start();
    chk("restart_score", score, 12'h000);
    frame(200, 220, ncol, nsp);
    ssum = 0;
    for (int i = 0; i < 99; i++) begin pass_one(nsp); ssum += nsp; end
    chk("p99_score", score, 12'h099);
    chk("p99_pulses", 12'(ssum), 12'(99));
    pass_one(nsp);
    chk("p100_score", score, 12'h100);
    for (int i = 0; i < 899; i++) pass_one(nsp);
    chk("p999_score", score, 12'h999);
    pass_one(nsp);
    chk("sat_score", score, 12'h999);
    chk("sat_sp", 12'(nsp), 12'h1);

    frame(600, 470, ncol, nsp);
`ifdef PIPE_COLLIDER_FLOOR_EN
    chk("floor_col", 12'(ncol), 12'h1);
    chk("floor_best", best, 12'h999);
`else
    chk("floor_col", 12'(ncol), 12'h0);
    chk("floor_play", 12'(playing), 12'h1);
`endif

    do_reset();
    chk_reset_vals("rst2");
    do_start();
    frame(200, 220, ncol, nsp);
    for (int i = 0; i < 5; i++) pass_one(nsp);
    frame(165, 190, ncol, nsp);
    chk("d5_col", 12'(ncol), 12'h1);
    chk("d5_best", best, 12'h005);
    // reset with a frame in flight: nothing may leak out afterwards
    @(negedge clk);
    frame_tick = 1'b1; reset = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; reset = 1'b0;
    chk_reset_vals("rst3");
    csum = 0; ssum = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      csum += int'(collide); ssum += int'(score_pulse);
    end
    chk("rst3_nopulse", 12'(csum + ssum), 12'h0);
    chk("rst3_state", 12'({playing, game_over}), 12'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
